// File: rtl/aes_session_ctrl.sv
// aes_session_ctrl: SPI-frame driven session controller sequencing multi-block messages through an AES core.
// Optional CBC chaining is built when AES_CBC_EN is defined; otherwise the engine runs ECB.
module aes_session_ctrl #(
  parameter int KEY_W      = 256,
  parameter int BLK_W      = 128,
  parameter int MAX_BLOCKS = 16,
  parameter int CNT_W      = $clog2(MAX_BLOCKS)
)(
  input  logic               sclk,
  input  logic               rst_n,
  input  logic [KEY_W+3:0]   rx_frame,
  input  logic               rx_done,
  output logic               core_start,
  output logic [3:0]         core_nk,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLK_W-1:0]   core_din,
  input  logic               core_done,
  input  logic [BLK_W-1:0]   core_dout,
  output logic [BLK_W-1:0]   tx_word,
  output logic               tx_load,
  output logic [7:0]         status
);
  typedef enum logic [1:0] {IDLE, READY, BUSY, DRAIN} state_e;
  localparam logic [CNT_W:0] ONE = 1;
  state_e state_q, state_d;
  logic [3:0] nk_q, nk_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] din_q, din_d, tx_q, tx_d, mask;
  logic start_q, start_d, load_q, load_d, kv_q, kv_d, last_q, last_d;
  logic [1:0] size_q, size_d;
  logic [2:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] len_q, len_d, cnt_nx;
  logic [1:0] op, sz;
  logic [KEY_W-1:0] pld;
  logic [BLK_W-1:0] blk;
  logic busy, abort, key_ok, len_ok, data_ok, done_ok, wrap;
  assign op      = rx_frame[1:0];
  assign sz      = rx_frame[3:2];
  assign pld     = rx_frame[KEY_W+3:4];
  assign blk     = pld[BLK_W-1:0];
  assign busy    = state_q == BUSY || state_q == DRAIN;
  assign abort   = rx_done && op == 2'b11;
  assign key_ok  = rx_done && !busy && op == 2'b00 && sz != 2'b11;
  assign len_ok  = rx_done && state_q == READY && op == 2'b01;
  assign data_ok = rx_done && state_q == READY && op == 2'b10;
  assign done_ok = core_done && state_q == BUSY && !abort;
  assign cnt_nx  = {1'b0, cnt_q} + ONE;
  assign wrap    = cnt_nx == len_q;
`ifdef AES_CBC_EN
  logic [BLK_W-1:0] chain_q, chain_d;
  assign chain_d = (abort || key_ok) ? '0 : len_ok ? blk : done_ok ? core_dout : chain_q;
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  assign mask = chain_q;
`else
  assign mask = '0;
`endif
  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    key_d   = key_q;
    din_d   = din_q;
    tx_d    = tx_q;
    kv_d    = kv_q;
    size_d  = size_q;
    err_d   = err_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    start_d = data_ok;
    load_d  = done_ok;
    if (abort) begin
      err_d   = '0;
      last_d  = 1'b0;
      cnt_d   = '0;
      // an ABORT coinciding with core_done has nothing left to drain
      state_d = (state_q == BUSY && !core_done) ? DRAIN : kv_q ? READY : IDLE;
    end else begin
      if (rx_done && busy) err_d[1] = 1'b1;
      if (rx_done && state_q == IDLE && op == 2'b10) err_d[2] = 1'b1;
      if (rx_done && !busy && op == 2'b00 && sz == 2'b11) err_d[0] = 1'b1;
      if (key_ok) begin
        nk_d    = sz == 2'b00 ? 4'd4 : sz == 2'b01 ? 4'd6 : 4'd8;
        key_d   = pld;
        kv_d    = 1'b1;
        size_d  = sz;
        cnt_d   = '0;
        state_d = READY;
      end
      if (len_ok) begin
        len_d = {1'b0, pld[KEY_W-1 -: CNT_W]} + ONE;
        cnt_d = '0;
      end
      if (data_ok) begin
        din_d   = blk ^ mask;
        state_d = BUSY;
      end
      if (done_ok) begin
        tx_d    = core_dout;
        last_d  = wrap;
        cnt_d   = wrap ? '0 : cnt_nx[CNT_W-1:0];
        state_d = READY;
      end
      if (core_done && state_q == DRAIN) state_d = READY;
    end
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      nk_q    <= '0;
      key_q   <= '0;
      din_q   <= '0;
      tx_q    <= '0;
      kv_q    <= 1'b0;
      size_q  <= '0;
      err_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= ONE;
      start_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nk_q    <= nk_d;
      key_q   <= key_d;
      din_q   <= din_d;
      tx_q    <= tx_d;
      kv_q    <= kv_d;
      size_q  <= size_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      start_q <= start_d;
      load_q  <= load_d;
    end
  assign core_start = start_q;
  assign core_nk    = nk_q;
  assign core_key   = key_q;
  assign core_din   = din_q;
  assign tx_word    = tx_q;
  assign tx_load    = load_q;
  assign status     = {kv_q, busy, size_q, err_q, last_q};
endmodule
